// File: rtl/aes_pkg.sv
// aes_pkg: shared constants for the SubBytes engine.
//   BLOCK_W / BYTE_W / NUM_BYTES : block geometry (128-bit block, 16 bytes)
//   stateT                       : engine FSM state encoding
//   SBOX_FWD                     : 256-entry forward S-box, index 0 first
//   SBOX_INV                     : 256-entry inverse S-box (only with SUB_BYTES_INV_EN)
// Config macro: SUB_BYTES_INV_EN
package aes_pkg;

  localparam int BLOCK_W   = 128;
  localparam int BYTE_W    = 8;
  localparam int NUM_BYTES = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } stateT;

  // Ascending packed range so that SBOX_FWD[x] is the entry for byte value x.
  localparam logic [0:255][7:0] SBOX_FWD = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

`ifdef SUB_BYTES_INV_EN
  localparam logic [0:255][7:0] SBOX_INV = {
    128'h52096ad53036a538bf40a39e81f3d7fb,
    128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e,
    128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692,
    128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506,
    128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673,
    128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b,
    128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f,
    128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961,
    128'h172b047eba77d626e169146355210c7d
  };
`endif

endpackage

// File: rtl/sbox_lane.sv
// sbox_lane: one combinational byte substitution.
//   byteIn  : byte to substitute
//   mode    : 0 = forward S-box, 1 = inverse S-box
//   byteOut : substituted byte
// Config macro: SUB_BYTES_INV_EN (without it the lane is forward-only and
// mode has no effect).
module sbox_lane
  import aes_pkg::*;
(
  input  logic [BYTE_W-1:0] byteIn,
  input  logic              mode,
  output logic [BYTE_W-1:0] byteOut
);

`ifdef SUB_BYTES_INV_EN
  assign byteOut = mode ? SBOX_INV[byteIn] : SBOX_FWD[byteIn];
`else
  logic unusedMode;
  assign unusedMode = mode;
  assign byteOut    = SBOX_FWD[byteIn];
`endif

endmodule

// File: rtl/sub_bytes_engine.sv
// sub_bytes_engine: iterative AES SubBytes / InvSubBytes over a 128-bit block,
// LANES bytes per cycle.
//   clk, rst_n          : clock, synchronous active-low reset
//   in_valid / in_ready : block input handshake (ready only in IDLE)
//   mode                : 0 forward, 1 inverse; captured with the block
//   in_data             : input block, byte 0 = bits [127:120]
//   out_valid/out_ready : result handshake (valid only in DONE)
//   out_data            : working register (meaningful while out_valid)
//   busy                : high outside IDLE
// Config macro: SUB_BYTES_INV_EN (undefined: forward only, mode ignored).
//
// state | meaning
// IDLE  | waiting for a block, in_ready high
// BUSY  | substituting one group of LANES bytes per cycle
// DONE  | result held on out_data until out_ready
module sub_bytes_engine
  import aes_pkg::*;
#(
  parameter int LANES = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               mode,
  input  logic [BLOCK_W-1:0] in_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [BLOCK_W-1:0] out_data,
  output logic               busy
);

  localparam int GROUPS = NUM_BYTES / LANES;
  localparam int CNT_W  = (GROUPS > 1) ? $clog2(GROUPS) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(GROUPS - 1);

  if (!(LANES == 1 || LANES == 2 || LANES == 4 || LANES == 8 || LANES == 16)) begin : gLanesCheck
    $error("sub_bytes_engine: LANES must be 1, 2, 4, 8 or 16");
  end

  stateT                              state;
  logic [CNT_W-1:0]                   cnt;
  logic [0:NUM_BYTES-1][BYTE_W-1:0]   work;
  logic                               laneMode;
  logic [3:0]                         baseIdx;
  logic [BYTE_W-1:0]                  laneIn  [LANES];
  logic [BYTE_W-1:0]                  laneOut [LANES];

`ifdef SUB_BYTES_INV_EN
  logic modeReg;
  assign laneMode = modeReg;
`else
  logic unusedMode;
  assign unusedMode = mode;
  assign laneMode   = 1'b0;
`endif

  // First byte of the current group; wraps harmlessly to 0 when LANES=16.
  assign baseIdx = 4'(int'(cnt) * LANES);

  for (genvar g = 0; g < LANES; g++) begin : gLane
    assign laneIn[g] = work[baseIdx + 4'(g)];
    sbox_lane uLane (
      .byteIn  (laneIn[g]),
      .mode    (laneMode),
      .byteOut (laneOut[g])
    );
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      work  <= '0;
`ifdef SUB_BYTES_INV_EN
      modeReg <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            work  <= in_data;
            cnt   <= '0;
            state <= BUSY;
`ifdef SUB_BYTES_INV_EN
            modeReg <= mode;
`endif
          end
        end
        BUSY: begin
          for (int i = 0; i < LANES; i++) begin
            work[baseIdx + 4'(i)] <= laneOut[i];
          end
          if (cnt == LAST_CNT) begin
            cnt   <= '0;
            state <= DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);
  assign out_data  = work;

endmodule

// File: tb/tb_sub_bytes_engine.sv
// Testbench for sub_bytes_engine. Expected values come from a GF(2^8)
// reference model (multiplicative inverse + affine map) built at start-up.
// Config macro: SUB_BYTES_INV_EN (selects the expected mode behaviour).
module tb_sub_bytes_engine;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic         mode;
  logic [127:0] in_data;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_data;
  logic         busy;

  int nVec = 0;
  int nErr = 0;

  sub_bytes_engine #(.LANES(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .mode      (mode),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .busy      (busy)
  );

  // Sweep instances for the other lane counts.
  localparam int SW_LANES [4] = '{1, 2, 8, 16};
  logic         swInValid  [4];
  logic         swInReady  [4];
  logic         swOutValid [4];
  logic         swBusy     [4];
  logic [127:0] swOutData  [4];

  for (genvar k = 0; k < 4; k++) begin : gSweep
    sub_bytes_engine #(.LANES(SW_LANES[k])) uSw (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (swInValid[k]),
      .in_ready  (swInReady[k]),
      .mode      (1'b0),
      .in_data   (128'h0),
      .out_valid (swOutValid[k]),
      .out_ready (1'b1),
      .out_data  (swOutData[k]),
      .busy      (swBusy[k])
    );
  end

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- reference model ----------------
  logic [7:0] fwdTab [256];
  logic [7:0] invTab [256];

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] x, input int n);
    return 8'((x << n) | (x >> (8 - n)));
  endfunction

  task automatic buildTables();
    for (int a = 0; a < 256; a++) begin
      logic [7:0] v = 8'h00;
      for (int b = 1; b < 256; b++)
        if (gmul(8'(a), 8'(b)) == 8'h01) v = 8'(b);
      fwdTab[a] = v ^ rotl(v, 1) ^ rotl(v, 2) ^ rotl(v, 3) ^ rotl(v, 4) ^ 8'h63;
    end
    for (int a = 0; a < 256; a++) invTab[fwdTab[a]] = 8'(a);
  endtask

  function automatic logic [127:0] refBlock(input logic [127:0] d, input logic m);
    logic [127:0] r;
    logic         useInv;
`ifdef SUB_BYTES_INV_EN
    useInv = m;
`else
    useInv = 1'b0 & m;
`endif
    for (int b = 0; b < 16; b++) begin
      logic [7:0] x = d[127 - 8*b -: 8];
      r[127 - 8*b -: 8] = useInv ? invTab[x] : fwdTab[x];
    end
    return r;
  endfunction

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
    nVec++;
    if (got !== exp) begin
      nErr++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic waitIdle();
    int n = 0;
    while (!in_ready && n < 40) begin
      @(posedge clk); #1; n++;
    end
  endtask

  // Entered at posedge+1; accepts one block, returns result and edges from
  // acceptance to out_valid, then completes the output handshake.
  task automatic runBlock(input logic m, input logic [127:0] d, input bit toggle,
                          output logic [127:0] res, output int lat);
    waitIdle();
    in_valid = 1'b1; mode = m; in_data = d;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 40) begin
      if (toggle) begin
        mode = ~mode;
        in_data = {$urandom, $urandom, $urandom, $urandom};
        in_valid = 1'($urandom_range(0, 1));
      end
      @(posedge clk); #1; lat++;
    end
    res = out_data;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    in_valid = 1'b0;
  endtask

  typedef struct {
    logic         m;
    logic [127:0] d;
    logic [127:0] e;
  } vecT;

  vecT tbl [6];

  initial begin
    logic [127:0] res;
    logic [127:0] held;
    logic [127:0] d;
    logic         m;
    int           lat;
    int           n;
    int           swLat [4];
    logic [127:0] swRes [4];
    bit           sawOut;

    rst_n = 1'b0; in_valid = 1'b0; mode = 1'b0; in_data = '0; out_ready = 1'b0;
    for (int k = 0; k < 4; k++) swInValid[k] = 1'b0;
    buildTables();

    tbl[0] = '{1'b0, 128'h19a09ae93df4c6f8e3e28d48be2b2a08, 128'hd4e0b81e27bfb44111985d52aef1e530};
`ifdef SUB_BYTES_INV_EN
    tbl[1] = '{1'b1, 128'hd4e0b81e27bfb44111985d52aef1e530, 128'h19a09ae93df4c6f8e3e28d48be2b2a08};
    tbl[4] = '{1'b1, 128'h0, {16{8'h52}}};
`else
    tbl[1] = '{1'b1, 128'hd4e0b81e27bfb44111985d52aef1e530,
               refBlock(128'hd4e0b81e27bfb44111985d52aef1e530, 1'b0)};
    tbl[4] = '{1'b1, 128'h0, {16{8'h63}}};
`endif
    tbl[2] = '{1'b0, 128'h0, {16{8'h63}}};
    tbl[3] = '{1'b0, {16{8'hff}}, {16{8'h16}}};
    tbl[5] = '{1'b0, 128'h00112233445566778899aabbccddeeff, 128'h638293c31bfc33f5c4eeacea4bc12816};

    // Reset state
    repeat (2) @(posedge clk);
    #1; rst_n = 1'b1;
    check("rst_in_ready", 128'(in_ready), 128'd1);
    check("rst_out_valid", 128'(out_valid), 128'd0);
    check("rst_busy", 128'(busy), 128'd0);
    check("rst_out_data", out_data, 128'h0);

    // Directed table
    for (int i = 0; i < 6; i++) begin
      runBlock(tbl[i].m, tbl[i].d, 1'b0, res, lat);
      check($sformatf("tbl%0d_data", i), res, tbl[i].e);
      check($sformatf("tbl%0d_latency", i), 128'(lat), 128'd4);
    end

    // Random blocks, every third one with inputs churning while busy
    for (int i = 0; i < 24; i++) begin
      m = 1'($urandom_range(0, 1));
      d = {$urandom, $urandom, $urandom, $urandom};
      runBlock(m, d, (i % 3) == 0, res, lat);
      check($sformatf("rnd%0d_data", i), res, refBlock(d, m));
      check($sformatf("rnd%0d_latency", i), 128'(lat), 128'd4);
    end

    // Back-pressure in DONE with a stray in_valid pulse
    waitIdle();
    d = 128'h0f1e2d3c4b5a69788796a5b4c3d2e1f0;
    in_valid = 1'b1; mode = 1'b0; in_data = d;
    @(posedge clk); #1;
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 40) begin
      @(posedge clk); #1; n++;
    end
    held = out_data;
    check("hold_first_data", held, refBlock(d, 1'b0));
    for (int i = 0; i < 5; i++) begin
      in_valid = (i == 1);
      in_data = {$urandom, $urandom, $urandom, $urandom};
      mode = 1'b1;
      @(posedge clk); #1;
      check($sformatf("hold%0d_data", i), out_data, held);
      check($sformatf("hold%0d_out_valid", i), 128'(out_valid), 128'd1);
      check($sformatf("hold%0d_in_ready", i), 128'(in_ready), 128'd0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("hold_release_in_ready", 128'(in_ready), 128'd1);
    check("hold_release_out_valid", 128'(out_valid), 128'd0);
    sawOut = 1'b0;
    repeat (6) begin
      @(posedge clk); #1;
      if (out_valid || busy) sawOut = 1'b1;
    end
    check("hold_stray_ignored", 128'(sawOut), 128'd0);

    // Reset mid-BUSY
    waitIdle();
    in_valid = 1'b1; mode = 1'b0; in_data = {16{8'ha5}};
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    check("abort_in_ready", 128'(in_ready), 128'd1);
    check("abort_out_valid", 128'(out_valid), 128'd0);
    check("abort_out_data", out_data, 128'h0);
    sawOut = 1'b0;
    repeat (8) begin
      @(posedge clk); #1;
      if (out_valid) sawOut = 1'b1;
    end
    check("abort_no_output", 128'(sawOut), 128'd0);
    d = 128'h3243f6a8885a308d313198a2e0370734;
    runBlock(1'b1, d, 1'b0, res, lat);
    check("after_abort_data", res, refBlock(d, 1'b1));
    check("after_abort_latency", 128'(lat), 128'd4);

    // Lane-count sweep, all-zero block, forward
    for (int k = 0; k < 4; k++) begin
      check($sformatf("sweep%0d_in_ready", SW_LANES[k]), 128'(swInReady[k]), 128'd1);
      swLat[k] = -1;
      swRes[k] = '0;
      swInValid[k] = 1'b1;
    end
    @(posedge clk); #1;
    for (int k = 0; k < 4; k++) swInValid[k] = 1'b0;
    for (int c = 1; c <= 20; c++) begin
      @(posedge clk); #1;
      for (int k = 0; k < 4; k++) begin
        if (swOutValid[k] && swLat[k] < 0) begin
          swLat[k] = c;
          swRes[k] = swOutData[k];
        end
      end
    end
    for (int k = 0; k < 4; k++) begin
      check($sformatf("sweep%0d_latency", SW_LANES[k]), 128'(swLat[k]), 128'(16 / SW_LANES[k]));
      check($sformatf("sweep%0d_data", SW_LANES[k]), swRes[k], refBlock(128'h0, 1'b0));
      check($sformatf("sweep%0d_busy_after", SW_LANES[k]), 128'(swBusy[k]), 128'd0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
    $finish;
  end

endmodule

// File: doc/sub_bytes_engine.md
SUB_BYTES_ENGINE -- requirements
Module: sub_bytes_engine

Interface
REQ-001 SHALL have parameter LANES, default 4, S-box lanes processed per cycle; legal values 1, 2, 4, 8, 16.
REQ-002 SHALL have clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have rst_n  input  1  reset, synchronous, active-low.
REQ-004 SHALL have in_valid  input  1  upstream block valid.
REQ-005 SHALL have in_ready  output  1  engine accepts a block this cycle.
REQ-006 SHALL have mode  input  1  0 = SubBytes (forward), 1 = InvSubBytes; sampled with the block.
REQ-007 SHALL have in_data  input  128  state block; byte 0 = bits [127:120].
REQ-008 SHALL have out_valid  output  1  result available.
REQ-009 SHALL have out_ready  input  1  downstream accepts result.
REQ-010 SHALL have out_data  output  128  substituted block, same byte order as in_data.
REQ-011 SHALL have busy  output  1  high whenever state is not IDLE.

Function
REQ-012 FSM states SHALL be IDLE, BUSY, DONE.
REQ-013 in_ready SHALL equal 1 in IDLE only; out_valid SHALL equal 1 in DONE only.
REQ-014 IDLE: on in_valid&&in_ready, capture in_data and mode into internal registers, clear counter cnt, go to BUSY.
REQ-015 BUSY: each cycle replace bytes cnt*LANES .. cnt*LANES+LANES-1 with their S-box (mode 0) or inverse S-box (mode 1) value; increment cnt.
REQ-016 BUSY SHALL go to DONE on the edge processing the final group (cnt = 16/LANES-1); cnt width SHALL be clog2(16/LANES), minimum 1 bit.
REQ-017 Latency: out_valid SHALL rise exactly 16/LANES clock edges after the acceptance edge.
REQ-018 DONE: out_data SHALL be held stable until out_valid&&out_ready, then go to IDLE the same edge.
REQ-019 in_valid, in_data and mode changes during BUSY/DONE SHALL be ignored; captured mode SHALL govern the whole block.
REQ-020 Back-to-back: a new block SHALL be accepted no earlier than the cycle after the DONE handshake (throughput one block per 16/LANES+2 cycles).
REQ-021 out_data outside DONE SHALL present the working register (not meaningful; verifier checks only when out_valid=1).

Reset
REQ-022 rst_n=0 at a rising edge SHALL force IDLE, cnt=0, working register=0, captured mode=0, regardless of current state, including mid-BUSY.
REQ-023 After reset: in_ready=1, out_valid=0, busy=0, out_data=128'h0; an aborted block SHALL produce no output.

Configuration
REQ-024 Macro SUB_BYTES_INV_EN defined: inverse tables instantiated, mode honoured as in REQ-006.
REQ-025 SUB_BYTES_INV_EN undefined: no inverse tables; mode SHALL be ignored and all blocks processed forward; port list unchanged.

Structure
REQ-026 Shared package aes_pkg SHALL hold the 256-entry forward and inverse S-box constant tables, the FSM state typedef, and block/byte width constants.
REQ-027 One sub-module sbox_lane (8-bit in, mode, 8-bit out, combinational lookup) SHALL be instantiated LANES times.
REQ-028 An illegal LANES value SHALL cause an elaboration-time error.

Verification
REQ-029 LANES=4, mode=0, in_data=19a09ae93df4c6f8e3e28d48be2b2a08 -> out_data=d4e0b81e27bfb44111985d52aef1e530, out_valid 4 edges after acceptance.
REQ-030 mode=1, in_data=d4e0b81e27bfb44111985d52aef1e530 -> out_data=19a09ae93df4c6f8e3e28d48be2b2a08; with macro undefined, out_data equals forward result instead.
REQ-031 Sweep LANES=1,2,8,16 with in_data=all 00 mode 0 -> all 63; latency 16, 8, 2, 1 edges respectively.
REQ-032 Hold out_ready=0 for 5 cycles in DONE -> out_data, out_valid stable, in_ready=0; second in_valid pulse ignored; raise out_ready -> IDLE next edge.
REQ-033 Assert rst_n=0 for one edge mid-BUSY -> IDLE, in_ready=1, out_valid=0, out_data=0; no output for aborted block; next block processes correctly.
REQ-034 Toggle mode and in_data during BUSY -> result matches the captured block and mode only.
